// File: rtl/instr_fetch_unit_pkg.sv
// Shared CPU definitions used by the instruction fetch unit and its helpers.
package instr_fetch_unit_pkg;

  // Architectural widths and the power-on fetch address.
  localparam int XLEN_DEFAULT = 64;
  localparam logic [63:0] RESET_PC_DEFAULT = 64'h8000_0000;

  // Every fetched instruction is a 32-bit word; decode consumes it zero-extended to 64 bits.
  localparam int INSTR_LEN = 32;
  localparam int OUT_INSTR_W = 64;

  // Fetch sequencer states:
  //   ST_REQ  - request driven on the memory bus
  //   ST_WAIT - one request outstanding, waiting for its response
  //   ST_HOLD - a fetched word is buffered for decode
  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bundles the fetch unit's memory, redirect and decode-side handshake signals.
interface instr_fetch_unit_if #(
  parameter int XLEN = 64
) ();
  import instr_fetch_unit_pkg::*;

  // Instruction memory request channel.
  logic                   imem_req_valid;
  logic                   imem_req_ready;
  logic [XLEN-1:0]        imem_req_addr;

  // Instruction memory response channel; one response per accepted request.
  logic                   imem_rsp_valid;
  logic [INSTR_LEN-1:0]   imem_rsp_data;

  // Control-flow change from execute.
  logic                   redirect_valid;
  logic [XLEN-1:0]        redirect_pc;

  // Instruction stream towards decode.
  logic                   out_valid;
  logic                   out_ready;
  logic [OUT_INSTR_W-1:0] out_instr;
  logic [XLEN-1:0]        out_pc;

  // View seen by the fetch unit itself.
  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data,
    input  redirect_valid,
    input  redirect_pc,
    output out_valid,
    output out_instr,
    output out_pc,
    input  out_ready
  );

  // View seen by the surrounding memory, execute and decode logic.
  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data,
    output redirect_valid,
    output redirect_pc,
    input  out_valid,
    input  out_instr,
    input  out_pc,
    output out_ready
  );

endinterface

// File: rtl/ifu_out_reg.sv
// Output holding register between fetch and decode: loads a fetched word with
// its PC, holds it until consumed, and can be cleared by the sequencer.
module ifu_out_reg
  import instr_fetch_unit_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic                   clear,
  input  logic [INSTR_LEN-1:0]   load_word,
  input  logic [XLEN-1:0]        load_pc,
  output logic                   valid,
  output logic [OUT_INSTR_W-1:0] instr,
  output logic [XLEN-1:0]        pc
);

  // Load takes precedence over clear; the sequencer never asserts both, so the
  // ordering only matters as a tie-break. Clear drops valid but keeps the
  // payload, which is meaningless once valid is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      instr <= '0;
      pc    <= '0;
    end else if (load) begin
      valid <= 1'b1;
      instr <= {{(OUT_INSTR_W-INSTR_LEN){1'b0}}, load_word};
      pc    <= load_pc;
    end else if (clear) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Single-outstanding instruction fetch unit: requests one word at a time from
// instruction memory, buffers it for decode, and honours redirects at any time.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input logic                clk,
  input logic                rst,
  instr_fetch_unit_if.master bus
);

  fetch_state_t    state;
  logic [XLEN-1:0] pc;
  logic            kill;

  logic            rsp_accept;
  logic            out_load;
  logic            out_clear;
  logic            out_fire;
  logic [XLEN-1:0] redirect_target;

  logic                   out_valid_q;
  logic [OUT_INSTR_W-1:0] out_instr_q;
  logic [XLEN-1:0]        out_pc_q;

  // Redirect targets are forced to a 4-byte boundary so fetch addresses stay aligned.
  assign redirect_target = bus.redirect_pc & ~{{(XLEN-2){1'b0}}, 2'b11};

  // A response is only useful when it belongs to a live request and no redirect
  // is overriding it this cycle; decode handshake completes only while a word is held.
  assign rsp_accept = (state == ST_WAIT) && bus.imem_rsp_valid && !kill;
  assign out_fire   = (state == ST_HOLD) && out_valid_q && bus.out_ready;
  assign out_load   = !rst && !bus.redirect_valid && rsp_accept;
  assign out_clear  = !rst && (bus.redirect_valid || out_fire);

  // The request is a direct function of the state register, so it is glitch-free.
  assign bus.imem_req_valid = (state == ST_REQ);
  assign bus.imem_req_addr  = pc;

  assign bus.out_valid = out_valid_q;
  assign bus.out_instr = out_instr_q;
  assign bus.out_pc    = out_pc_q;

  // Fetch sequencer: redirect wins over every other event; kill marks an
  // in-flight request whose response must be discarded when it arrives.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_REQ;
      pc    <= RESET_PC;
      kill  <= 1'b0;
    end else if (bus.redirect_valid) begin
      pc <= redirect_target;
      unique case (state)
        ST_REQ: begin
          if (bus.imem_req_ready) begin
            state <= ST_WAIT;
            kill  <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (bus.imem_rsp_valid) begin
            state <= ST_REQ;
            kill  <= 1'b0;
          end else begin
            kill  <= 1'b1;
          end
        end
        ST_HOLD: begin
          state <= ST_REQ;
          kill  <= 1'b0;
        end
        default: begin
          state <= ST_REQ;
          kill  <= 1'b0;
        end
      endcase
    end else begin
      unique case (state)
        ST_REQ: begin
          if (bus.imem_req_ready) begin
            state <= ST_WAIT;
            kill  <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (bus.imem_rsp_valid) begin
            kill <= 1'b0;
            if (kill) begin
              state <= ST_REQ;
            end else begin
              state <= ST_HOLD;
              pc    <= pc + XLEN'(4);
            end
          end
        end
        ST_HOLD: begin
          if (out_fire) begin
            state <= ST_REQ;
          end
        end
        default: begin
          state <= ST_REQ;
          kill  <= 1'b0;
        end
      endcase
    end
  end

  ifu_out_reg #(
    .XLEN (XLEN)
  ) u_out_reg (
    .clk       (clk),
    .rst       (rst),
    .load      (out_load),
    .clear     (out_clear),
    .load_word (bus.imem_rsp_data),
    .load_pc   (pc),
    .valid     (out_valid_q),
    .instr     (out_instr_q),
    .pc        (out_pc_q)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios with literal
// expectations followed by randomized traffic against a transaction-level model.
module tb_instr_fetch_unit;

  localparam logic [63:0] RST_PC = 64'h8000_0000;

  logic clk;
  logic rst;

  instr_fetch_unit_if #(.XLEN(64)) bus ();

  instr_fetch_unit #(
    .XLEN     (64),
    .RESET_PC (RST_PC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int assert_count = 0;
  int fail_count   = 0;

  // Reference model, described in terms of outstanding requests and a one-entry buffer.
  bit          model_live = 0;
  bit          m_out;
  bit          m_stale;
  bit          m_full;
  logic [63:0] m_pc;
  logic [31:0] m_instr;
  logic [63:0] m_opc;

  // Memory model.
  bit          mem_pending = 0;
  int          mem_cnt     = 0;
  int          mem_lat     = 0;
  logic [31:0] mem_data;
  bit          override_en = 0;
  logic [31:0] override_word;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [63:0] addr);
    if (addr == 64'h8000_0000) return 32'h0000_0513;
    return addr[31:0] ^ addr[63:32] ^ 32'hA5C3_0F00;
  endfunction

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    assert_count++;
    if (act !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs on the falling edge, advance the models on the rising edge.
  task automatic apply_stimulus(input logic r, input logic rdy, input logic redir,
                                input logic [63:0] rpc, input logic ordy);
    logic        rsp;
    logic [31:0] data;
    bit          m_req;
    bit          acc;
    bit          use_rsp;
    logic [63:0] req_addr;
    @(negedge clk);
    rsp  = !r && mem_pending && (mem_cnt == 0);
    data = rsp ? mem_data : $urandom();
    rst                = r;
    bus.imem_req_ready = rdy;
    bus.imem_rsp_valid = rsp;
    bus.imem_rsp_data  = data;
    bus.redirect_valid = redir;
    bus.redirect_pc    = rpc;
    bus.out_ready      = ordy;
    @(posedge clk);
    m_req    = !m_out && !m_full;
    acc      = m_req && rdy;
    use_rsp  = m_out && rsp;
    req_addr = m_pc;
    if (r) begin
      m_out = 0; m_stale = 0; m_full = 0;
      m_pc = RST_PC; m_instr = '0; m_opc = '0;
      model_live = 1;
    end else if (redir) begin
      if (acc) begin
        m_out = 1; m_stale = 1;
      end else if (use_rsp) begin
        m_out = 0; m_stale = 0;
      end else if (m_out) begin
        m_stale = 1;
      end
      m_full = 0;
      m_pc   = rpc & ~64'h3;
    end else if (acc) begin
      m_out = 1; m_stale = 0;
    end else if (use_rsp) begin
      m_out = 0;
      if (m_stale) begin
        m_stale = 0;
      end else begin
        m_full = 1; m_instr = data; m_opc = m_pc; m_pc = m_pc + 64'd4;
      end
    end else if (m_full && ordy) begin
      m_full = 0;
    end
    if (r || rsp) begin
      mem_pending = 0;
    end else if (mem_pending) begin
      mem_cnt--;
    end else if (acc) begin
      mem_pending = 1;
      mem_cnt     = mem_lat;
      mem_data    = override_en ? override_word : mem_word(req_addr);
      override_en = 0;
    end
  endtask

  // Convenience for idle-ish cycles with no redirect.
  task automatic cyc(input logic rdy, input logic ordy);
    apply_stimulus(1'b0, rdy, 1'b0, 64'h0, ordy);
  endtask

  // Compare the DUT against the model on every falling edge once reset has been seen.
  always @(negedge clk) begin
    if (model_live) begin
      check_output("req_valid", {63'b0, bus.imem_req_valid}, {63'b0, !m_out && !m_full});
      if (!m_out && !m_full) check_output("req_addr", bus.imem_req_addr, m_pc);
      check_output("out_valid", {63'b0, bus.out_valid}, {63'b0, m_full});
      if (m_full) begin
        check_output("out_instr", bus.out_instr, {32'b0, m_instr});
        check_output("out_pc", bus.out_pc, m_opc);
      end
    end
  end

  initial begin
    logic [63:0] rpc;
    rst = 1'b1;
    bus.imem_req_ready = 0; bus.imem_rsp_valid = 0; bus.imem_rsp_data = '0;
    bus.redirect_valid = 0; bus.redirect_pc = '0; bus.out_ready = 0;

    // Reset and first fetch with a one-cycle memory.
    apply_stimulus(1'b1, 1'b0, 1'b0, 64'h0, 1'b0);
    apply_stimulus(1'b1, 1'b0, 1'b0, 64'h0, 1'b0);
    #1;
    check_output("lit_reset_req_valid", {63'b0, bus.imem_req_valid}, 64'd1);
    check_output("lit_reset_addr", bus.imem_req_addr, 64'h8000_0000);
    check_output("lit_reset_out_valid", {63'b0, bus.out_valid}, 64'd0);
    cyc(1'b1, 1'b0);
    #1 check_output("lit_wait_no_req", {63'b0, bus.imem_req_valid}, 64'd0);
    cyc(1'b0, 1'b0);
    #1;
    check_output("lit_first_valid", {63'b0, bus.out_valid}, 64'd1);
    check_output("lit_first_instr", bus.out_instr, 64'h0000_0000_0000_0513);
    check_output("lit_first_pc", bus.out_pc, 64'h8000_0000);
    check_output("lit_model_instr", {32'b0, m_instr}, 64'h513);

    // Decode stalls for five cycles: output frozen, no new request.
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 1'b0);
      #1;
      check_output("lit_hold_valid", {63'b0, bus.out_valid}, 64'd1);
      check_output("lit_hold_pc", bus.out_pc, 64'h8000_0000);
      check_output("lit_hold_instr", bus.out_instr, 64'h513);
      check_output("lit_hold_no_req", {63'b0, bus.imem_req_valid}, 64'd0);
    end
    cyc(1'b0, 1'b1);
    #1;
    check_output("lit_next_req_valid", {63'b0, bus.imem_req_valid}, 64'd1);
    check_output("lit_next_req_addr", bus.imem_req_addr, 64'h8000_0004);
    check_output("lit_next_out_valid", {63'b0, bus.out_valid}, 64'd0);

    // Redirect while waiting: the late response is discarded.
    mem_lat = 1; override_en = 1; override_word = 32'hDEAD_BEEF;
    cyc(1'b1, 1'b1);
    apply_stimulus(1'b0, 1'b0, 1'b1, 64'h8000_0103, 1'b1);
    #1 check_output("lit_kill_wait", {63'b0, bus.imem_req_valid}, 64'd0);
    cyc(1'b0, 1'b1);
    #1;
    check_output("lit_kill_no_out", {63'b0, bus.out_valid}, 64'd0);
    check_output("lit_kill_req_valid", {63'b0, bus.imem_req_valid}, 64'd1);
    check_output("lit_kill_addr", bus.imem_req_addr, 64'h8000_0100);
    mem_lat = 0;

    // Memory back-pressure with a redirect in the middle.
    cyc(1'b0, 1'b0);
    #1 check_output("lit_stall_addr0", bus.imem_req_addr, 64'h8000_0100);
    apply_stimulus(1'b0, 1'b0, 1'b1, 64'h8000_0200, 1'b0);
    #1 check_output("lit_stall_redir", bus.imem_req_addr, 64'h8000_0200);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    #1 check_output("lit_stall_addr3", bus.imem_req_addr, 64'h8000_0200);

    // Fetch from the last word of the address space and wrap to zero.
    apply_stimulus(1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    #1 check_output("lit_wrap_out_pc", bus.out_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    cyc(1'b0, 1'b1);
    #1;
    check_output("lit_wrap_addr", bus.imem_req_addr, 64'h0);
    check_output("lit_wrap_model_pc", m_pc, 64'h0);

    // Reset while waiting and while holding.
    cyc(1'b1, 1'b0);
    apply_stimulus(1'b1, 1'b0, 1'b0, 64'h0, 1'b0);
    #1;
    check_output("lit_rst_wait_out", {63'b0, bus.out_valid}, 64'd0);
    check_output("lit_rst_wait_addr", bus.imem_req_addr, 64'h8000_0000);
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    #1 check_output("lit_pre_rst_hold", {63'b0, bus.out_valid}, 64'd1);
    apply_stimulus(1'b1, 1'b0, 1'b0, 64'h0, 1'b0);
    #1;
    check_output("lit_rst_hold_out", {63'b0, bus.out_valid}, 64'd0);
    check_output("lit_rst_hold_req", {63'b0, bus.imem_req_valid}, 64'd1);
    check_output("lit_rst_hold_addr", bus.imem_req_addr, 64'h8000_0000);

    // Randomized traffic checked cycle by cycle against the model.
    for (int i = 0; i < 4000; i++) begin
      if (!mem_pending) mem_lat = $urandom_range(0, 3);
      rpc = {$urandom(), $urandom()};
      if ($urandom_range(0, 3) == 0) rpc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
      apply_stimulus($urandom_range(0, 199) == 0,
                     $urandom_range(0, 2) != 0,
                     $urandom_range(0, 11) == 0,
                     rpc,
                     $urandom_range(0, 2) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
